// File: rtl/sdram_pkg.sv
// Shared constants and types for the SDRAM request arbiter.
// Master IDs double as indices into every per-master vector.
package sdram_pkg;
  localparam int NUM_MASTERS = 3;
  localparam int RFIFO_DEPTH = 4;
  localparam int ID_W        = 2;
  localparam int ADDR_W      = 26;
  localparam int DATA_W      = 32;
  localparam int STRB_W      = 4;

  localparam logic [ID_W-1:0] CPU_I = 2'd0;
  localparam logic [ID_W-1:0] CPU_D = 2'd1;
  localparam logic [ID_W-1:0] VGA   = 2'd2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;
endpackage

// File: rtl/sdram_arbiter_if.sv
// Bundle of master-side and controller-side signals around the arbiter.
// Handshake: a master holds m_request and its fields until m_ack; the arbiter holds sdram_* until a cycle with sdram_ready=1.
interface sdram_arbiter_if;
  import sdram_pkg::*;

  logic [NUM_MASTERS-1:0]             m_request;
  logic [NUM_MASTERS-1:0][ADDR_W-1:0] m_address;
  logic [NUM_MASTERS-1:0]             m_write;
  logic [NUM_MASTERS-1:0]             m_burst;
  logic [NUM_MASTERS-1:0][STRB_W-1:0] m_wstrb;
  logic [NUM_MASTERS-1:0][DATA_W-1:0] m_wdata;
  logic [NUM_MASTERS-1:0]             m_ack;
  logic [DATA_W-1:0]                  m_rdata;
  logic [ADDR_W-1:0]                  m_raddress;
  logic [NUM_MASTERS-1:0]             m_rvalid;
  logic [NUM_MASTERS-1:0]             m_complete;

  logic [NUM_MASTERS-1:0] sdram_request;
  logic                   sdram_ready;
  logic [ADDR_W-1:0]      sdram_address;
  logic                   sdram_write;
  logic                   sdram_burst;
  logic [STRB_W-1:0]      sdram_wstrb;
  logic [DATA_W-1:0]      sdram_wdata;
  logic [DATA_W-1:0]      sdram_rdata;
  logic [ADDR_W-1:0]      sdram_raddress;
  logic [NUM_MASTERS-1:0] sdram_rvalid;
  logic                   sdram_complete;

  // slave = the arbiter; master = the masters plus the SDRAM controller around it
  modport slave (
    input  m_request, m_address, m_write, m_burst, m_wstrb, m_wdata,
    output m_ack, m_rdata, m_raddress, m_rvalid, m_complete,
    output sdram_request, sdram_address, sdram_write, sdram_burst, sdram_wstrb, sdram_wdata,
    input  sdram_ready, sdram_rdata, sdram_raddress, sdram_rvalid, sdram_complete
  );

  modport master (
    output m_request, m_address, m_write, m_burst, m_wstrb, m_wdata,
    input  m_ack, m_rdata, m_raddress, m_rvalid, m_complete,
    input  sdram_request, sdram_address, sdram_write, sdram_burst, sdram_wstrb, sdram_wdata,
    output sdram_ready, sdram_rdata, sdram_raddress, sdram_rvalid, sdram_complete
  );
endinterface

// File: rtl/sdram_id_fifo.sv
// FIFO of master IDs for reads accepted by the controller but not yet completed.
// A push and a pop in the same cycle both take effect and leave the count unchanged.
module sdram_id_fifo
  import sdram_pkg::*;
#(
  parameter int DEPTH = RFIFO_DEPTH,
  parameter int W     = ID_W
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign full    = (count_q == CNT_FULL);
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_ptr_q];

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      if (do_push && !do_pop)      count_q <= count_q + CNT_ONE;
      else if (do_pop && !do_push) count_q <= count_q - CNT_ONE;
    end
  end
endmodule

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller among several masters.
// One request in flight at a time; reads are tracked by ID until the controller completes them.
module sdram_arbiter #(
  parameter int NUM_MASTERS = sdram_pkg::NUM_MASTERS,
  parameter int RFIFO_DEPTH = sdram_pkg::RFIFO_DEPTH
) (
  input  logic                  clock,
  input  logic                  reset_n,
  sdram_arbiter_if.slave        bus,
  output logic                  err_underflow,
  output sdram_pkg::arb_state_t dbg_state_o
);
  import sdram_pkg::*;

  localparam logic [ID_W-1:0] LAST_RESET = ID_W'(NUM_MASTERS - 1);

  arb_state_t             state_q, state_d;
  logic [ID_W-1:0]        last_q, last_d, gnt_id_q, gnt_id_d;
  logic [NUM_MASTERS-1:0] req_q, req_d, outst_q, outst_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic                   write_q, write_d, burst_q, burst_d, err_q, err_d;
  logic [STRB_W-1:0]      wstrb_q, wstrb_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;

  logic [NUM_MASTERS-1:0] eligible, ack_c, cpl_c;
  logic                   pick_valid;
  logic [ID_W-1:0]        pick_id, cand;
  logic                   fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [ID_W-1:0]        fifo_head;

  sdram_id_fifo #(.DEPTH(RFIFO_DEPTH), .W(ID_W)) u_id_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .din     (gnt_id_q),
    .dout    (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // A master with a read in flight waits for its completion before it may ask again.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_MASTERS; i++)
      eligible[i] = bus.m_request[i] && !outst_q[i] && (bus.m_write[i] || !fifo_full);
  end

  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    cand       = '0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      cand = ID_W'((int'(last_q) + k) % NUM_MASTERS);
      if (!pick_valid && eligible[cand]) begin
        pick_valid = 1'b1;
        pick_id    = cand;
      end
    end
  end

  assign fifo_pop = bus.sdram_complete && !fifo_empty;
  assign err_d    = err_q || (bus.sdram_complete && fifo_empty);

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    gnt_id_d  = gnt_id_q;
    req_d     = req_q;
    addr_d    = addr_q;
    write_d   = write_q;
    burst_d   = burst_q;
    wstrb_d   = wstrb_q;
    wdata_d   = wdata_q;
    outst_d   = outst_q;
    ack_c     = '0;
    fifo_push = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          gnt_id_d       = pick_id;
          req_d          = '0;
          req_d[pick_id] = 1'b1;
          addr_d         = bus.m_address[pick_id];
          write_d        = bus.m_write[pick_id];
          burst_d        = bus.m_burst[pick_id];
          wstrb_d        = bus.m_wstrb[pick_id];
          wdata_d        = bus.m_wdata[pick_id];
          state_d        = GRANT;
        end
      end
      GRANT: begin
        // Captured fields stay put even if the master drops its request meanwhile.
        if (bus.sdram_ready) begin
          ack_c   = req_q;
          last_d  = gnt_id_q;
          req_d   = '0;
          state_d = IDLE;
          if (!write_q) begin
            fifo_push         = 1'b1;
            outst_d[gnt_id_q] = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (fifo_pop) outst_d[fifo_head] = 1'b0;
  end

  always_comb begin
    cpl_c = '0;
    if (fifo_pop) cpl_c[fifo_head] = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      last_q   <= LAST_RESET;
      gnt_id_q <= '0;
      req_q    <= '0;
      outst_q  <= '0;
      addr_q   <= '0;
      write_q  <= 1'b0;
      burst_q  <= 1'b0;
      wstrb_q  <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      gnt_id_q <= gnt_id_d;
      req_q    <= req_d;
      outst_q  <= outst_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      burst_q  <= burst_d;
      wstrb_q  <= wstrb_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
    end
  end

  assign bus.m_ack          = ack_c;
  assign bus.m_complete     = cpl_c;
  assign bus.m_rvalid       = bus.sdram_rvalid;
  assign bus.m_rdata        = bus.sdram_rdata;
  assign bus.m_raddress     = bus.sdram_raddress;
  assign bus.sdram_request  = req_q;
  assign bus.sdram_address  = addr_q;
  assign bus.sdram_write    = write_q;
  assign bus.sdram_burst    = burst_q;
  assign bus.sdram_wstrb    = wstrb_q;
  assign bus.sdram_wdata    = wdata_q;
  assign err_underflow      = err_q;
  assign dbg_state_o        = state_q;
endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: directed scenarios then random traffic, all checked each cycle
// against a transaction-level model (grant choice, read-ID queue, sticky underflow flag).
module tb_sdram_arbiter;
  import sdram_pkg::*;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       err_underflow;
  arb_state_t dbg_state;

  sdram_arbiter_if bus ();

  sdram_arbiter #(.NUM_MASTERS(NUM_MASTERS), .RFIFO_DEPTH(RFIFO_DEPTH)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .bus           (bus),
    .err_underflow (err_underflow),
    .dbg_state_o   (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / model state ----------------
  int          n_checks = 0;
  int          n_pass   = 0;
  int          mdl_gnt;            // master currently presented to the controller, -1 if none
  int          mdl_last;
  logic [2:0]  mdl_outst;
  logic [1:0]  exp_q[$];           // expected order of read completions
  logic        mdl_err;
  logic [25:0] mdl_addr;
  logic        mdl_write, mdl_burst;
  logic [3:0]  mdl_wstrb;
  logic [31:0] mdl_wdata;
  logic [2:0]  last_ack, obs_req, obs_ack, obs_cpl;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    mdl_gnt   = -1;
    mdl_last  = 2;
    mdl_outst = 3'b000;
    exp_q.delete();
    mdl_err   = 1'b0;
    last_ack  = 3'b000;
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    bus.m_request      = '0;
    bus.m_address      = '0;
    bus.m_write        = '0;
    bus.m_burst        = '0;
    bus.m_wstrb        = '0;
    bus.m_wdata        = '0;
    bus.sdram_ready    = 1'b0;
    bus.sdram_rdata    = '0;
    bus.sdram_raddress = '0;
    bus.sdram_rvalid   = '0;
    bus.sdram_complete = 1'b0;
  endtask

  task automatic set_req(input logic [1:0] id, input logic wr, input logic bu,
                         input logic [25:0] a, input logic [3:0] s, input logic [31:0] d);
    bus.m_request[id] = 1'b1;
    bus.m_write[id]   = wr;
    bus.m_burst[id]   = bu;
    bus.m_address[id] = a;
    bus.m_wstrb[id]   = s;
    bus.m_wdata[id]   = d;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    clear_inputs();
    #1;
    check("rst_sdram_request", 64'(bus.sdram_request), 64'(3'b000));
    check("rst_m_ack",         64'(bus.m_ack),         64'(3'b000));
    check("rst_m_complete",    64'(bus.m_complete),    64'(3'b000));
    check("rst_err_underflow", 64'(err_underflow),     64'(1'b0));
    check("rst_state",         64'(dbg_state),         64'(IDLE));
    check("rst_address",       64'(bus.sdram_address), 64'(26'h0));
    check("rst_wdata",         64'(bus.sdram_wdata),   64'(32'h0));
    check("rst_ctrl",          64'({bus.sdram_write, bus.sdram_burst, bus.sdram_wstrb}), 64'(6'h0));
    model_reset();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  // One clock: check outputs against the model, advance the model, then masters drop acked requests.
  task automatic tick();
    logic [2:0] e_req, e_ack, e_cpl;
    logic [1:0] ci;
    int         pre_size, pick;
    #1;
    e_req = (mdl_gnt >= 0) ? 3'(1 << mdl_gnt) : 3'b000;
    e_ack = (mdl_gnt >= 0 && bus.sdram_ready) ? e_req : 3'b000;
    e_cpl = (bus.sdram_complete && exp_q.size() > 0) ? 3'(1 << exp_q[0]) : 3'b000;
    check("sdram_request", 64'(bus.sdram_request), 64'(e_req));
    check("m_ack",         64'(bus.m_ack),         64'(e_ack));
    check("m_complete",    64'(bus.m_complete),    64'(e_cpl));
    check("m_rvalid",      64'(bus.m_rvalid),      64'(bus.sdram_rvalid));
    check("m_rdata",       64'(bus.m_rdata),       64'(bus.sdram_rdata));
    check("m_raddress",    64'(bus.m_raddress),    64'(bus.sdram_raddress));
    check("err_underflow", 64'(err_underflow),     64'(mdl_err));
    if (mdl_gnt >= 0) begin
      check("sdram_address", 64'(bus.sdram_address), 64'(mdl_addr));
      check("sdram_ctrl",    64'({bus.sdram_write, bus.sdram_burst, bus.sdram_wstrb}),
                             64'({mdl_write, mdl_burst, mdl_wstrb}));
      check("sdram_wdata",   64'(bus.sdram_wdata),   64'(mdl_wdata));
    end
    obs_req = bus.sdram_request;
    obs_ack = bus.m_ack;
    obs_cpl = bus.m_complete;

    pre_size = exp_q.size();
    if (mdl_gnt >= 0) begin
      if (bus.sdram_ready) begin
        mdl_last = mdl_gnt;
        if (!mdl_write) begin
          exp_q.push_back(2'(mdl_gnt));
          mdl_outst[2'(mdl_gnt)] = 1'b1;
        end
        mdl_gnt = -1;
      end
    end else begin
      pick = -1;
      for (int k = 1; k <= 3; k++) begin
        ci = 2'((mdl_last + k) % 3);
        if (pick < 0 && bus.m_request[ci] && !mdl_outst[ci] &&
            (bus.m_write[ci] || exp_q.size() < RFIFO_DEPTH))
          pick = int'(ci);
      end
      if (pick >= 0) begin
        ci        = 2'(pick);
        mdl_gnt   = pick;
        mdl_addr  = bus.m_address[ci];
        mdl_write = bus.m_write[ci];
        mdl_burst = bus.m_burst[ci];
        mdl_wstrb = bus.m_wstrb[ci];
        mdl_wdata = bus.m_wdata[ci];
      end
    end
    if (bus.sdram_complete) begin
      if (pre_size > 0) begin
        mdl_outst[exp_q[0]] = 1'b0;
        void'(exp_q.pop_front());
      end else begin
        mdl_err = 1'b1;
      end
    end
    last_ack = e_ack;
    @(negedge clock);
    bus.m_request = bus.m_request & ~last_ack;
  endtask

  // ---------------- stimulus ----------------
  logic [20:0] hist;
  logic [8:0]  cpl_hist;
  int          n_req, n_ack, n_cpl, n_g0, n_g2;

  initial begin
    reset_n = 1'b0;
    clear_inputs();
    model_reset();
    @(negedge clock);
    apply_reset();

    // All three masters read with the controller always ready: 001, 010, 100 with idle gaps.
    set_req(2'd0, 1'b0, 1'b0, 26'h0000100, 4'hF, 32'h0);
    set_req(2'd1, 1'b0, 1'b0, 26'h0000200, 4'hF, 32'h0);
    set_req(2'd2, 1'b0, 1'b0, 26'h0000300, 4'hF, 32'h0);
    bus.sdram_ready = 1'b1;
    hist = '0;
    for (int i = 0; i < 7; i++) begin
      tick();
      hist = {hist[17:0], obs_req};
    end
    check("rr_sequence", 64'(hist), 64'(21'b000_001_000_010_000_100_000));
    bus.sdram_ready    = 1'b0;
    bus.sdram_complete = 1'b1;
    cpl_hist = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      cpl_hist = {cpl_hist[5:0], obs_cpl};
    end
    check("complete_order", 64'(cpl_hist), 64'(9'b001_010_100));
    bus.sdram_complete = 1'b0;

    // Master 1 write held through three not-ready cycles.
    set_req(2'd1, 1'b1, 1'b0, 26'h0001234, 4'b0011, 32'hDEADBEEF);
    n_req = 0; n_ack = 0; n_cpl = 0;
    for (int i = 0; i < 7; i++) begin
      bus.sdram_ready = (i >= 4);
      tick();
      if (i == 1) check("write_addr", 64'(bus.sdram_address), 64'(26'h0001234));
      if (obs_req == 3'b010) n_req++;
      if (obs_ack == 3'b010) n_ack++;
      if (obs_cpl != 3'b000) n_cpl++;
    end
    check("write_hold_cycles", 64'(n_req), 64'(4));
    check("write_ack_pulses",  64'(n_ack), 64'(1));
    check("write_no_complete", 64'(n_cpl), 64'(0));

    // Master 0 burst read, 16 data beats, then completion.
    set_req(2'd0, 1'b0, 1'b1, 26'(24'h0ABCD0), 4'hF, 32'h0);
    bus.sdram_ready = 1'b1;
    repeat (2) tick();
    bus.sdram_ready = 1'b0;
    n_req = 0;
    for (int i = 0; i < 16; i++) begin
      bus.sdram_rvalid   = 3'b001;
      bus.sdram_rdata    = $urandom;
      bus.sdram_raddress = 26'($urandom);
      tick();
      if (bus.m_rvalid == 3'b001) n_req++;
    end
    check("burst_rvalid_beats", 64'(n_req), 64'(16));
    bus.sdram_rvalid   = 3'b000;
    bus.sdram_complete = 1'b1;
    tick();
    check("burst_complete", 64'(obs_cpl), 64'(3'b001));
    bus.sdram_complete = 1'b0;
    set_req(2'd0, 1'b0, 1'b0, 26'h0000040, 4'hF, 32'h0);
    bus.sdram_ready = 1'b1;
    repeat (2) tick();
    check("m0_regranted", 64'(obs_req), 64'(3'b001));
    bus.sdram_ready    = 1'b0;
    bus.sdram_complete = 1'b1;
    tick();
    bus.sdram_complete = 1'b0;

    // Master 2 with a read outstanding must wait while master 0 is served.
    set_req(2'd2, 1'b0, 1'b0, 26'h0002000, 4'hF, 32'h0);
    bus.sdram_ready = 1'b1;
    repeat (2) tick();
    set_req(2'd2, 1'b0, 1'b0, 26'h0002004, 4'hF, 32'h0);
    set_req(2'd0, 1'b0, 1'b0, 26'h0000080, 4'hF, 32'h0);
    n_g0 = 0; n_g2 = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (obs_req == 3'b001) n_g0++;
      if (obs_req == 3'b100) n_g2++;
    end
    check("m2_blocked", 64'(n_g2), 64'(0));
    check("m0_served",  64'(n_g0), 64'(1));
    bus.sdram_complete = 1'b1;
    tick();
    check("m2_complete", 64'(obs_cpl), 64'(3'b100));
    bus.sdram_complete = 1'b0;
    repeat (2) tick();
    check("m2_regranted", 64'(obs_req), 64'(3'b100));
    bus.sdram_ready    = 1'b0;
    bus.sdram_complete = 1'b1;
    repeat (2) tick();
    bus.sdram_complete = 1'b0;

    // Completion with nothing outstanding.
    bus.sdram_complete = 1'b1;
    tick();
    check("underflow_no_complete", 64'(obs_cpl), 64'(3'b000));
    bus.sdram_complete = 1'b0;
    repeat (3) tick();
    check("underflow_sticky", 64'(err_underflow), 64'(1'b1));

    // Reset while presenting a third read with two reads outstanding.
    set_req(2'd0, 1'b0, 1'b0, 26'h0000010, 4'hF, 32'h0);
    set_req(2'd1, 1'b0, 1'b0, 26'h0000020, 4'hF, 32'h0);
    set_req(2'd2, 1'b0, 1'b0, 26'h0000030, 4'hF, 32'h0);
    bus.sdram_ready = 1'b1;
    repeat (4) tick();
    bus.sdram_ready = 1'b0;
    repeat (2) tick();
    check("pre_reset_state",   64'(dbg_state),         64'(GRANT));
    check("pre_reset_request", 64'(bus.sdram_request), 64'(3'b100));
    apply_reset();
    set_req(2'd0, 1'b0, 1'b0, 26'h0000011, 4'hF, 32'h0);
    set_req(2'd1, 1'b0, 1'b0, 26'h0000021, 4'hF, 32'h0);
    set_req(2'd2, 1'b0, 1'b0, 26'h0000031, 4'hF, 32'h0);
    bus.sdram_ready    = 1'b1;
    bus.sdram_complete = 1'b1;
    tick();
    check("post_reset_fifo_empty", 64'(obs_cpl), 64'(3'b000));
    bus.sdram_complete = 1'b0;
    tick();
    check("post_reset_first_grant", 64'(obs_req), 64'(3'b001));

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 3; i++) begin
        if (!bus.m_request[i] && $urandom_range(0, 3) == 0)
          set_req(2'(i), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  26'($urandom), 4'($urandom), $urandom);
      end
      bus.sdram_ready    = ($urandom_range(0, 2) != 0);
      bus.sdram_rvalid   = 3'($urandom_range(0, 7));
      bus.sdram_rdata    = $urandom;
      bus.sdram_raddress = 26'($urandom);
      bus.sdram_complete = (exp_q.size() > 0) && ($urandom_range(0, 3) == 0);
      tick();
    end

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 Parameter NUM_MASTERS, default 3: number of bus masters; it SHALL equal the sdram_request width.
REQ-002 Parameter RFIFO_DEPTH, default 4: outstanding-read ID FIFO depth, a power of 2.
REQ-003 Ports SHALL be:
  clock  in  1  rising-edge clock.
  reset_n  in  1  asynchronous, active-low reset.
  m_request  in  3  per-master request, held high until acked.
  m_address  in  3x26  per-master byte address.
  m_write  in  3  1 = write.
  m_burst  in  3  1 = burst read.
  m_wstrb  in  3x4  byte enables.
  m_wdata  in  3x32  write data.
  m_ack  out  3  one-cycle pulse: request accepted.
  m_rdata  out  32  read data, broadcast to all masters.
  m_raddress  out  26  read address, broadcast.
  m_rvalid  out  3  read-data strobe per master.
  m_complete  out  3  one-cycle pulse: read transaction finished.
  sdram_request  out  3  one-hot ID of the granted master.
  sdram_ready  in  1  controller accepts the presented request.
  sdram_address / _write / _burst / _wstrb / _wdata  out  26/1/1/4/32  granted request fields.
  sdram_rdata / sdram_raddress / sdram_rvalid / sdram_complete  in  32/26/3/1  controller response.
  err_underflow  out  1  sticky: sdram_complete arrived with the FIFO empty.

Function
REQ-004 FSM states SHALL be IDLE and GRANT.
REQ-005 IDLE: if any eligible master is present, register its fields onto the sdram_* outputs, set sdram_request one-hot, and go to GRANT. Otherwise drive sdram_request = 0.
REQ-006 A master SHALL be eligible when:
  - m_request is high;
  - it has no read outstanding;
  - for reads, the FIFO is not full.
REQ-007 Selection SHALL be round-robin: search starts at last_grant+1 and wraps modulo 3.
REQ-008 GRANT: all sdram_* request outputs SHALL hold stable until a cycle in which sdram_ready = 1. In that cycle:
  - m_ack[id] pulses, combinationally;
  - last_grant <= id;
  - if the request is a read, push id to the FIFO and set outstanding[id];
  - go to IDLE with sdram_request = 0 in the next cycle.
REQ-009 Writes SHALL produce no m_complete; m_ack alone terminates a write.
REQ-010 m_rvalid SHALL equal sdram_rvalid with zero latency; m_rdata = sdram_rdata and m_raddress = sdram_raddress, both passed through.
REQ-011 On sdram_complete = 1 with the FIFO non-empty:
  - pop the head ID;
  - pulse m_complete[head] in the same cycle;
  - clear outstanding[head].
REQ-012 A simultaneous push and pop SHALL both take effect, and the FIFO count SHALL stay unchanged.
REQ-013 On sdram_complete with the FIFO empty: no pop, no m_complete pulse, and err_underflow is set until reset.
REQ-014 A master dropping m_request while in GRANT is illegal. The arbiter SHALL keep presenting the captured request regardless.
REQ-015 Minimum spacing between accepted requests SHALL be 2 cycles (GRANT, then IDLE).

Reset
REQ-016 While reset_n = 0, the following outputs SHALL be 0: sdram_request, m_ack, m_complete, err_underflow.
REQ-017 While reset_n = 0: state = IDLE, FIFO empty, outstanding = 0, last_grant = 2 (master 0 wins first).
REQ-018 The captured sdram_address/_write/_burst/_wstrb/_wdata registers SHALL reset to 0.
REQ-019 Reset asserted mid-GRANT or with reads outstanding SHALL discard all state. The controller SHALL be reset concurrently.

Structure
REQ-020 The shared package sdram_pkg SHALL hold:
  - NUM_MASTERS;
  - master-ID constants (CPU_I = 0, CPU_D = 1, VGA = 2);
  - RFIFO_DEPTH;
  - the state enum.
REQ-021 The FIFO SHALL be one sub-module, sdram_id_fifo: 2-bit-wide entries, with push, pop, full and empty.

Verification
REQ-022 m_request = 3'b111, all reads, sdram_ready = 1 continuously -> sdram_request = 001, 010, 100, each asserted for one cycle with IDLE cycles between.
REQ-023 Master 1 writes addr 0x0001234, wstrb 4'b0011, wdata 0xDEADBEEF, with sdram_ready low for 3 GRANT cycles then high:
  - outputs stable for 4 cycles;
  - m_ack = 010 for one cycle;
  - no m_complete.
REQ-024 Master 0 burst read is accepted; sdram_rvalid = 001 for 16 cycles, then sdram_complete -> m_rvalid mirrors sdram_rvalid, m_complete = 001 once, and master 0 is eligible again.
REQ-025 Master 2 read accepted and still outstanding, master 2 requests again -> not granted until its m_complete; master 0 is granted meanwhile.
REQ-026 sdram_complete pulsed with the FIFO empty -> err_underflow = 1 until reset_n = 0, and m_complete stays 000.
REQ-027 reset_n pulsed low while in GRANT with 2 reads outstanding -> after release: sdram_request = 0, FIFO empty, and the next grant goes to master 0.
